// File: rtl/axi_config_wr_arb.sv
// Round-robin arbiter serialising single-word config writes from PORTS requesters
// onto one register-file write port, with ack timeout and per-port completion pulse.
module axi_config_wr_arb #(
  parameter int PORTS      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORTS-1:0]              s_req_valid,
  output logic [PORTS-1:0]              s_req_ready,
  input  logic [PORTS*ADDR_WIDTH-1:0]   s_req_addr,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_req_data,
  input  logic [PORTS*STRB_WIDTH-1:0]   s_req_strb,
  output logic [PORTS-1:0]              s_rsp_valid,
  output logic                          s_rsp_err,
  output logic                          m_wr,
  output logic [ADDR_WIDTH-1:0]         m_waddr,
  output logic [DATA_WIDTH-1:0]         m_wdata,
  output logic [STRB_WIDTH-1:0]         m_wstrb,
  input  logic                          m_wack,
  output logic                          busy,
  output logic [$clog2(PORTS)-1:0]      grant_id
);

  localparam int IDW   = $clog2(PORTS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [PORTS-1:0] ONE = {{(PORTS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state, state_nx;
  logic [IDW-1:0]   rr, winner, idx;
  logic             any_vld;
  logic [CNT_W-1:0] cnt;
  logic             done, done_err;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [STRB_WIDTH-1:0] sel_strb;
  int               j;

  // Scan from rr+1 upward; iterating from the far end lets the nearest requester overwrite.
  always_comb begin
    winner  = '0;
    any_vld = 1'b0;
    idx     = '0;
    j       = 0;
    for (int i = PORTS; i >= 1; i--) begin
      j = int'(rr) + i;
      if (j >= PORTS) j = j - PORTS;
      idx = IDW'(j);
      if (s_req_valid[idx]) begin
        winner  = idx;
        any_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_strb = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (winner == IDW'(i)) begin
        sel_addr = s_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = s_req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_strb = s_req_strb[i*STRB_WIDTH +: STRB_WIDTH];
      end
    end
  end

  assign s_req_ready = (state == IDLE && any_vld) ? (ONE << winner) : '0;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    done_err = 1'b0;
    case (state)
      IDLE: if (any_vld) state_nx = ISSUE;
      ISSUE: begin
        if (m_wack) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else if (TIMEOUT <= 1) begin
          done     = 1'b1;
          done_err = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (m_wack) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else if (cnt >= CNT_W'(TIMEOUT - 1)) begin
          // This cycle is the TIMEOUT-th one spent waiting, counting the m_wr cycle.
          done     = 1'b1;
          done_err = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wr        <= 1'b0;
      m_waddr     <= '0;
      m_wdata     <= '0;
      m_wstrb     <= '0;
      grant_id    <= '0;
      rr          <= IDW'(PORTS - 1);
      cnt         <= '0;
      s_rsp_valid <= '0;
      s_rsp_err   <= 1'b0;
    end else begin
      m_wr        <= 1'b0;
      s_rsp_valid <= '0;
      s_rsp_err   <= 1'b0;
      if (state == IDLE && any_vld) begin
        m_waddr  <= sel_addr;
        m_wdata  <= sel_data;
        m_wstrb  <= sel_strb;
        m_wr     <= 1'b1;
        grant_id <= winner;
        rr       <= winner;
      end
      if (state == ISSUE)
        cnt <= CNT_W'(1);
      else if (state == WAIT && cnt != '1)
        cnt <= cnt + CNT_W'(1);
      if (done) begin
        s_rsp_valid <= ONE << grant_id;
        s_rsp_err   <= done_err;
      end
    end
  end

endmodule

// File: tb/tb_axi_config_wr_arb.sv
// Directed bench for axi_config_wr_arb: cycle vector table plus timeout, late-ack and reset sequences.
module tb_axi_config_wr_arb;

  localparam int PORTS = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = 4;
  localparam int NV    = 19;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PORTS-1:0]  s_req_valid, s_req_ready, s_rsp_valid;
  logic [PORTS*AW-1:0] s_req_addr;
  logic [PORTS*DW-1:0] s_req_data;
  logic [PORTS*SW-1:0] s_req_strb;
  logic              s_rsp_err, m_wr, m_wack, busy;
  logic [AW-1:0]     m_waddr;
  logic [DW-1:0]     m_wdata;
  logic [SW-1:0]     m_wstrb;
  logic [1:0]        grant_id;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axi_config_wr_arb #(.PORTS(PORTS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .STRB_WIDTH(SW), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_addr(s_req_addr), .s_req_data(s_req_data), .s_req_strb(s_req_strb),
    .s_rsp_valid(s_rsp_valid), .s_rsp_err(s_rsp_err),
    .m_wr(m_wr), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wack(m_wack), .busy(busy), .grant_id(grant_id)
  );

  typedef struct {
    bit         rst;
    logic [3:0] vld;
    logic       wack;
    logic [3:0] ready;
    logic       mwr;
    logic [3:0] rsp;
    logic       err;
    logic       busy;
    logic [1:0] gid;
  } vec_t;

  vec_t tbl [NV];

  function automatic logic [31:0] addr_of(input int p);
    return (p == 1) ? 32'h0000_0010 : 32'h0000_1000 + 32'(p * 4);
  endfunction

  function automatic logic [31:0] data_of(input int p);
    return (p == 1) ? 32'hA5A5_A5A5 : 32'h1234_0000 + 32'(p);
  endfunction

  function automatic logic [3:0] strb_of(input int p);
    return (p == 1) ? 4'hF : 4'(1 << p);
  endfunction

  function automatic vec_t mk(input bit r, input logic [3:0] v, input logic w,
                              input logic [3:0] rd, input logic mw, input logic [3:0] rs,
                              input logic e, input logic b, input logic [1:0] g);
    vec_t t;
    t.rst = r; t.vld = v; t.wack = w; t.ready = rd; t.mwr = mw;
    t.rsp = rs; t.err = e; t.busy = b; t.gid = g;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_req_valid = '0;
    m_wack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad;
    bit got;

    for (int p = 0; p < PORTS; p++) begin
      s_req_addr[p*AW +: AW] = addr_of(p);
      s_req_data[p*DW +: DW] = data_of(p);
      s_req_strb[p*SW +: SW] = strb_of(p);
    end
    s_req_valid = '0;
    m_wack = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst m_wr", 64'(m_wr), 64'(1'b0));
    chk("rst busy", 64'(busy), 64'(1'b0));
    chk("rst rsp", 64'({s_rsp_valid, s_rsp_err}), 64'(5'b0));
    chk("rst payload", 64'({m_waddr, m_wdata}), 64'(0));
    chk("rst grant", 64'(grant_id), 64'(2'd0));
    chk("rst ready", 64'(s_req_ready), 64'(4'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single write on port 1, acked in the m_wr cycle
    tbl[0]  = mk(1'b1, 4'b0010, 1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    tbl[1]  = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1);
    tbl[2]  = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b0, 2'd1);
    // All ports requesting from reset: 0,1,2,3,0 at one write per two cycles
    tbl[3]  = mk(1'b1, 4'b1111, 1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    tbl[4]  = mk(1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0);
    tbl[5]  = mk(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0);
    tbl[6]  = mk(1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1);
    tbl[7]  = mk(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b0, 4'b0010, 1'b0, 1'b0, 2'd1);
    tbl[8]  = mk(1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2);
    tbl[9]  = mk(1'b0, 4'b1111, 1'b1, 4'b1000, 1'b0, 4'b0100, 1'b0, 1'b0, 2'd2);
    tbl[10] = mk(1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd3);
    tbl[11] = mk(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b0, 2'd3);
    tbl[12] = mk(1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0);
    tbl[13] = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0);
    // Ports 0 and 3: after grant 0 port 3 wins, after grant 3 port 0 wins
    tbl[14] = mk(1'b0, 4'b1001, 1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    tbl[15] = mk(1'b0, 4'b1001, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd3);
    tbl[16] = mk(1'b0, 4'b1001, 1'b0, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b0, 2'd3);
    tbl[17] = mk(1'b0, 4'b1001, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0);
    tbl[18] = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0);

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].rst) do_reset();
      @(negedge clk);
      s_req_valid = tbl[i].vld;
      m_wack = tbl[i].wack;
      #1;
      chk($sformatf("vec%0d ready", i), 64'(s_req_ready), 64'(tbl[i].ready));
      chk($sformatf("vec%0d m_wr", i), 64'(m_wr), 64'(tbl[i].mwr));
      chk($sformatf("vec%0d rsp_valid", i), 64'(s_rsp_valid), 64'(tbl[i].rsp));
      chk($sformatf("vec%0d busy", i), 64'(busy), 64'(tbl[i].busy));
      chk($sformatf("vec%0d grant_id", i), 64'(grant_id), 64'(tbl[i].gid));
      if (tbl[i].rsp != 4'b0)
        chk($sformatf("vec%0d rsp_err", i), 64'(s_rsp_err), 64'(tbl[i].err));
      if (tbl[i].mwr) begin
        chk($sformatf("vec%0d waddr", i), 64'(m_waddr), 64'(addr_of(int'(tbl[i].gid))));
        chk($sformatf("vec%0d wdata/strb", i), 64'({m_wdata, m_wstrb}),
            64'({data_of(int'(tbl[i].gid)), strb_of(int'(tbl[i].gid))}));
      end
    end

    // Timeout on port 2 with no ack, then a late ack that must be ignored
    do_reset();
    @(negedge clk);
    s_req_valid = 4'b0100;
    m_wack = 1'b0;
    #1 chk("t3 ready", 64'(s_req_ready), 64'(4'b0100));
    @(negedge clk);
    s_req_valid = 4'b0000;
    #1 chk("t3 m_wr", 64'(m_wr), 64'(1'b1));
    n = 0; bad = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      #1;
      n++;
      if (s_rsp_valid != 4'b0) got = 1'b1;
      else if (m_wr || !busy) bad++;
    end
    chk("t3 wait state", 64'(bad), 64'(0));
    chk("t3 timeout cycles", 64'(n), 64'(16));
    chk("t3 rsp_valid", 64'(s_rsp_valid), 64'(4'b0100));
    chk("t3 rsp_err", 64'(s_rsp_err), 64'(1'b1));
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      m_wack = 1'b1;
      #1;
      if (k > 0 && (s_rsp_valid != 4'b0 || busy || m_wr)) bad++;
    end
    @(negedge clk);
    m_wack = 1'b0;
    #1 if (s_rsp_valid != 4'b0 || busy) bad++;
    chk("t3 late ack ignored", 64'(bad), 64'(0));

    // Ack three cycles after m_wr on port 0
    @(negedge clk);
    s_req_valid = 4'b0001;
    #1 chk("t4 ready", 64'(s_req_ready), 64'(4'b0001));
    @(negedge clk);
    s_req_valid = 4'b0000;
    #1 chk("t4 m_wr", 64'(m_wr), 64'(1'b1));
    bad = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      m_wack = (k == 3);
      #1 if (m_wr || s_rsp_valid != 4'b0 || !busy) bad++;
    end
    chk("t4 wait quiet", 64'(bad), 64'(0));
    @(negedge clk);
    m_wack = 1'b0;
    #1;
    chk("t4 rsp_valid", 64'(s_rsp_valid), 64'(4'b0001));
    chk("t4 rsp_err", 64'(s_rsp_err), 64'(1'b0));
    chk("t4 busy after ack", 64'(busy), 64'(1'b0));
    @(negedge clk);
    #1 chk("t4 single pulse", 64'(s_rsp_valid), 64'(4'b0000));

    // Asynchronous reset in the middle of WAIT
    @(negedge clk);
    s_req_valid = 4'b0010;
    @(negedge clk);
    s_req_valid = 4'b0000;
    #1 chk("t5 m_wr", 64'(m_wr), 64'(1'b1));
    @(negedge clk);
    @(negedge clk);
    #1 chk("t5 in wait", 64'({busy, grant_id}), 64'({1'b1, 2'd1}));
    #2 rst_n = 1'b0;
    #1;
    chk("t5 rst busy/grant", 64'({busy, grant_id}), 64'(3'b0));
    chk("t5 rst addr", 64'(m_waddr), 64'(0));
    chk("t5 rst data/strb", 64'({m_wdata, m_wstrb}), 64'(0));
    chk("t5 rst strobes", 64'({m_wr, s_rsp_valid, s_rsp_err, s_req_ready}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1 if (s_rsp_valid != 4'b0 || busy) bad++;
    end
    chk("t5 no rsp after reset", 64'(bad), 64'(0));
    @(negedge clk);
    s_req_valid = 4'b1111;
    #1 chk("t5 port0 first", 64'(s_req_ready), 64'(4'b0001));
    @(negedge clk);
    s_req_valid = 4'b0000;
    #1 chk("t5 grant", 64'({m_wr, grant_id}), 64'({1'b1, 2'd0}));
    m_wack = 1'b1;
    @(negedge clk);
    m_wack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
